// File: rtl/combination_lock_controller_pkg.sv
// Shared definitions for the combination-lock controller.
//   - lock_state_t : controller states
//   - DIGIT_W      : width of one keypad digit
//   - timer_width(): width of the shared unlock/lockout down-counter
package lock_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        ENTRY,
        CHECK,
        OPEN,
        PROG,
        LOCKOUT
    } lock_state_t;

    // One timer serves both the unlock window and the lockout, so it must
    // hold the larger of the two load values.
    function automatic int timer_width(input int unlock_cycles, input int lockout_cycles);
        int longest;
        longest = (unlock_cycles > lockout_cycles) ? unlock_cycles : lockout_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/combination_lock_controller_if.sv
// Keypad / actuator bundle of the combination-lock controller.
//   master : keypad front end (drives digits and commands, sees status)
//   slave  : the controller (samples digits and commands, drives status)
// Signals:
//   digit_in, digit_valid : keypad digit and its one-cycle strobe
//   clear                 : abort entry / relock early
//   prog_req              : start reprogramming while open
//   digit_ready           : digits are accepted
//   Lock, Led_on, alarm   : actuator, open LED, lockout alarm
//   fail_cnt              : consecutive failed attempts
interface combination_lock_controller_if #(
    parameter int FAIL_W = 2
);
    import lock_pkg::*;

    logic [DIGIT_W-1:0] digit_in;
    logic               digit_valid;
    logic               clear;
    logic               prog_req;
    logic               digit_ready;
    logic               Lock;
    logic               Led_on;
    logic               alarm;
    logic [FAIL_W-1:0]  fail_cnt;

    modport master (
        output digit_in, digit_valid, clear, prog_req,
        input  digit_ready, Lock, Led_on, alarm, fail_cnt
    );

    modport slave (
        input  digit_in, digit_valid, clear, prog_req,
        output digit_ready, Lock, Led_on, alarm, fail_cnt
    );

endinterface

// File: rtl/combination_lock_controller_timer.sv
// Loadable down-counter shared by the unlock window and the lockout.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   load       : load load_val this edge (wins over everything else)
//   load_val   : number of cycles to run
//   hold       : freeze the count
//   expired    : count has reached 1, i.e. this is the final cycle
module lock_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             hold,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (!hold && (count_reg > WIDTH'(1))) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Loaded with N, the count reads 1 during the N-th cycle after the load,
    // so the owner leaves its state on exactly the N-th following edge.
    assign expired = (count_reg == WIDTH'(1));

endmodule

// File: rtl/combination_lock_controller.sv
// Combination-lock sequencing controller.
// Collects CODE_LEN keypad digits, compares them with a reprogrammable stored
// code, opens the lock for UNLOCK_CYCLES, and after MAX_FAIL consecutive
// failures raises the alarm and ignores the keypad for LOCKOUT_CYCLES.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : keypad/actuator bundle (slave side), all outputs registered
module combination_lock_controller
    import lock_pkg::*;
#(
    parameter int                          CODE_LEN       = 4,
    parameter int                          MAX_FAIL       = 3,
    parameter int                          UNLOCK_CYCLES  = 16,
    parameter int                          LOCKOUT_CYCLES = 64,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE   = 16'h9D77
) (
    input logic                          clk,
    input logic                          reset,
    combination_lock_controller_if.slave bus
);

    localparam int CODE_W  = DIGIT_W * CODE_LEN;
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int TIMER_W = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

    lock_state_t         state_reg;
    logic [CODE_W-1:0]   entry_reg;
    logic [CODE_W-1:0]   code_reg;
    logic [CNT_W-1:0]    digit_cnt_reg;
    logic [FAIL_W-1:0]   fail_cnt_reg;
    logic                lock_reg;
    logic                led_reg;
    logic                alarm_reg;
    logic                ready_reg;

    logic [CODE_W-1:0]   entry_next;
    logic                last_digit;
    logic                code_match;
    logic                lockout_hit;
    logic [FAIL_W-1:0]   fail_inc;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_load_val;
    logic                timer_hold;
    logic                timer_expired;

    // First-entered digit ends up in the most significant nibble.
    assign entry_next  = (entry_reg << DIGIT_W) | CODE_W'(bus.digit_in);
    assign last_digit  = bus.digit_valid && (digit_cnt_reg == CNT_W'(CODE_LEN - 1));
    assign code_match  = (entry_reg == code_reg);
    assign lockout_hit = (int'(fail_cnt_reg) + 1 >= MAX_FAIL);
    assign fail_inc    = (fail_cnt_reg == FAIL_W'(MAX_FAIL)) ? fail_cnt_reg
                                                             : fail_cnt_reg + 1'b1;

    // CHECK always leaves after one cycle, so loading on every CHECK cycle
    // arms the timer exactly on entry to OPEN or LOCKOUT; a reload on the
    // mismatch-to-ENTRY path is harmless since ENTRY never looks at it.
    assign timer_load     = (state_reg == CHECK);
    assign timer_load_val = code_match ? TIMER_W'(UNLOCK_CYCLES) : TIMER_W'(LOCKOUT_CYCLES);
    assign timer_hold     = (state_reg == PROG);

    lock_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .load_val(timer_load_val),
        .hold    (timer_hold),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ENTRY;
            entry_reg     <= '0;
            code_reg      <= DEFAULT_CODE;
            digit_cnt_reg <= '0;
            fail_cnt_reg  <= '0;
            lock_reg      <= 1'b1;
            led_reg       <= 1'b0;
            alarm_reg     <= 1'b0;
            ready_reg     <= 1'b1;
        end else begin
            case (state_reg)
                ENTRY: begin
                    // clear outranks a same-cycle digit, which is dropped
                    if (bus.clear) begin
                        entry_reg     <= '0;
                        digit_cnt_reg <= '0;
                    end else if (bus.digit_valid) begin
                        entry_reg <= entry_next;
                        if (last_digit) begin
                            digit_cnt_reg <= '0;
                            state_reg     <= CHECK;
                            ready_reg     <= 1'b0;
                        end else begin
                            digit_cnt_reg <= digit_cnt_reg + 1'b1;
                        end
                    end
                end

                CHECK: begin
                    entry_reg <= '0;
                    if (code_match) begin
                        state_reg    <= OPEN;
                        fail_cnt_reg <= '0;
                        lock_reg     <= 1'b0;
                        led_reg      <= 1'b1;
                    end else if (lockout_hit) begin
                        state_reg    <= LOCKOUT;
                        fail_cnt_reg <= fail_inc;
                        alarm_reg    <= 1'b1;
                    end else begin
                        state_reg    <= ENTRY;
                        fail_cnt_reg <= fail_inc;
                        ready_reg    <= 1'b1;
                    end
                end

                OPEN: begin
                    // prog_req outranks both an early relock and expiry
                    if (bus.prog_req) begin
                        state_reg     <= PROG;
                        entry_reg     <= '0;
                        digit_cnt_reg <= '0;
                        ready_reg     <= 1'b1;
                    end else if (bus.clear || timer_expired) begin
                        state_reg <= ENTRY;
                        lock_reg  <= 1'b1;
                        led_reg   <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end

                PROG: begin
                    if (bus.clear) begin
                        // abort: old code stays in force
                        state_reg     <= ENTRY;
                        entry_reg     <= '0;
                        digit_cnt_reg <= '0;
                        lock_reg      <= 1'b1;
                        led_reg       <= 1'b0;
                    end else if (bus.digit_valid) begin
                        if (last_digit) begin
                            code_reg      <= entry_next;
                            entry_reg     <= '0;
                            digit_cnt_reg <= '0;
                            state_reg     <= ENTRY;
                            lock_reg      <= 1'b1;
                            led_reg       <= 1'b0;
                        end else begin
                            entry_reg     <= entry_next;
                            digit_cnt_reg <= digit_cnt_reg + 1'b1;
                        end
                    end
                end

                LOCKOUT: begin
                    if (timer_expired) begin
                        state_reg    <= ENTRY;
                        fail_cnt_reg <= '0;
                        alarm_reg    <= 1'b0;
                        ready_reg    <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= ENTRY;
                    entry_reg     <= '0;
                    digit_cnt_reg <= '0;
                    lock_reg      <= 1'b1;
                    led_reg       <= 1'b0;
                    alarm_reg     <= 1'b0;
                    ready_reg     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.digit_ready = ready_reg;
    assign bus.Lock        = lock_reg;
    assign bus.Led_on      = led_reg;
    assign bus.alarm       = alarm_reg;
    assign bus.fail_cnt    = fail_cnt_reg;

endmodule

// File: tb/tb_combination_lock_controller.sv
// Directed bench for combination_lock_controller with a cycle-level reference
// model (remaining-cycle counters and a digit queue) checked every cycle.
module tb_combination_lock_controller;

    localparam int UNLOCK  = 16;
    localparam int LOCKOUT = 64;
    localparam int MAXF    = 3;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    combination_lock_controller_if #(.FAIL_W(2)) bus ();

    combination_lock_controller dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_open_left;
    int          m_lock_left;
    int          m_fails;
    bit          m_check;
    bit          m_prog;
    logic [15:0] m_stored;
    logic [15:0] m_pending;
    logic [3:0]  m_q[$];

    function automatic logic [15:0] q_code();
        logic [15:0] c;
        c = '0;
        foreach (m_q[i]) c = {c[11:0], m_q[i]};
        return c;
    endfunction

    task automatic model_reset();
        m_open_left = 0;
        m_lock_left = 0;
        m_fails     = 0;
        m_check     = 0;
        m_prog      = 0;
        m_stored    = 16'h9D77;
        m_pending   = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_check) begin
            m_check = 0;
            if (m_pending == m_stored) begin
                m_open_left = UNLOCK;
                m_fails     = 0;
            end else begin
                m_fails++;
                if (m_fails >= MAXF) m_lock_left = LOCKOUT;
            end
        end else if (m_prog) begin
            if (bus.clear) begin
                m_prog = 0;
                m_open_left = 0;
                m_q.delete();
            end else if (bus.digit_valid) begin
                m_q.push_back(bus.digit_in);
                if (m_q.size() == 4) begin
                    m_stored = q_code();
                    m_q.delete();
                    m_prog = 0;
                    m_open_left = 0;
                end
            end
        end else if (m_open_left > 0) begin
            if (bus.prog_req) begin
                m_prog = 1;
                m_q.delete();
            end else if (bus.clear || m_open_left == 1) begin
                m_open_left = 0;
            end else begin
                m_open_left--;
            end
        end else begin
            if (bus.clear) begin
                m_q.delete();
            end else if (bus.digit_valid) begin
                m_q.push_back(bus.digit_in);
                if (m_q.size() == 4) begin
                    m_pending = q_code();
                    m_q.delete();
                    m_check = 1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // packed as {Lock, Led_on, alarm, digit_ready, fail_cnt[1:0]}
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                logic exp_lock;
                logic exp_ready;
                exp_lock  = !((m_open_left > 0) || m_prog);
                exp_ready = (m_lock_left == 0) && !m_check && ((m_open_left == 0) || m_prog);
                chk("model_compare",
                    {26'd0, bus.Lock, bus.Led_on, bus.alarm, bus.digit_ready, bus.fail_cnt},
                    {26'd0, exp_lock, !exp_lock, (m_lock_left > 0), exp_ready, 2'(m_fails)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        bus.digit_in    = d;
        bus.digit_valid = 1'b1;
        tick(1);
        bus.digit_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        logic [15:0] v;
        v = c;
        for (int i = 0; i < 4; i++) begin
            send_digit(v[15:12]);
            v = v << 4;
        end
        $display("entered code %04h: Lock=%0b fail_cnt=%0d", c, bus.Lock, bus.fail_cnt);
    endtask

    task automatic pulse(input bit is_clear);
        if (is_clear) bus.clear = 1'b1; else bus.prog_req = 1'b1;
        tick(1);
        bus.clear    = 1'b0;
        bus.prog_req = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        bus.digit_in     = '0;
        bus.digit_valid  = 1'b0;
        bus.clear        = 1'b0;
        bus.prog_req     = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // reset state
        tick(5);
        chk("reset_lock", bus.Lock, 1);
        chk("reset_led", bus.Led_on, 0);
        chk("reset_alarm", bus.alarm, 0);
        chk("reset_fail", bus.fail_cnt, 0);
        chk("reset_ready", bus.digit_ready, 1);

        // correct default code: open on second edge, 16 cycles open
        enter_code(16'h9D77);
        chk("check_still_locked", bus.Lock, 1);
        chk("check_not_ready", bus.digit_ready, 0);
        tick(1);
        chk("open_lock", bus.Lock, 0);
        chk("open_led", bus.Led_on, 1);
        tick(UNLOCK - 1);
        chk("open_last_cycle", bus.Lock, 0);
        tick(1);
        chk("relock_after_window", bus.Lock, 1);
        chk("fail_after_open", bus.fail_cnt, 0);

        // prog_req outside OPEN does nothing
        pulse(1'b0);
        chk("prog_req_ignored", bus.Lock, 1);

        // three failures -> lockout
        enter_code(16'h0000);
        tick(1);
        chk("fail_one", bus.fail_cnt, 1);
        enter_code(16'h0000);
        tick(1);
        chk("fail_two", bus.fail_cnt, 2);
        enter_code(16'h0000);
        tick(1);
        chk("lockout_alarm", bus.alarm, 1);
        chk("lockout_not_ready", bus.digit_ready, 0);
        enter_code(16'h9D77);
        tick(LOCKOUT - 5);
        chk("lockout_last_cycle", bus.alarm, 1);
        chk("lockout_still_locked", bus.Lock, 1);
        tick(1);
        chk("lockout_end_alarm", bus.alarm, 0);
        chk("lockout_end_fail", bus.fail_cnt, 0);
        chk("lockout_end_ready", bus.digit_ready, 1);

        // clear beats a simultaneous digit
        send_digit(4'h9);
        send_digit(4'hD);
        bus.clear = 1'b1;
        send_digit(4'h7);
        bus.clear = 1'b0;
        enter_code(16'h9D77);
        tick(1);
        chk("clear_drop_open", bus.Lock, 0);
        pulse(1'b1);
        chk("early_relock", bus.Lock, 1);

        // reprogram to 1234
        enter_code(16'h9D77);
        tick(1);
        pulse(1'b0);
        chk("prog_ready", bus.digit_ready, 1);
        chk("prog_unlocked", bus.Lock, 0);
        enter_code(16'h1234);
        chk("prog_done_lock", bus.Lock, 1);
        enter_code(16'h9D77);
        tick(1);
        chk("old_code_fails", bus.fail_cnt, 1);
        enter_code(16'h1234);
        tick(1);
        chk("new_code_opens", bus.Lock, 0);
        chk("new_code_fail_clr", bus.fail_cnt, 0);

        // abort programming after a freeze longer than the window
        pulse(1'b0);
        send_digit(4'h5);
        tick(UNLOCK + 4);
        chk("prog_timer_frozen", bus.Lock, 0);
        pulse(1'b1);
        chk("prog_abort_lock", bus.Lock, 1);
        enter_code(16'h1234);
        tick(1);
        chk("abort_keeps_code", bus.Lock, 0);

        // reset mid-programming restores the default code
        pulse(1'b0);
        send_digit(4'h5);
        send_digit(4'h6);
        rst_n = 1'b0;
        tick(1);
        chk("reset_prog_lock", bus.Lock, 1);
        chk("reset_prog_led", bus.Led_on, 0);
        rst_n = 1'b1;
        tick(1);
        enter_code(16'h9D77);
        tick(1);
        chk("default_restored", bus.Lock, 0);
        tick(UNLOCK);
        chk("final_relock", bus.Lock, 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
